ultrasonic_multi_ranger: RTL

Parametrised multi-channel ultrasonic ranging controller, successor to the single-channel fixed trigger generator. Fires TRIG_CYC-wide trigger pulses on NCH sensors, in round-robin or fixed-channel mode, one channel per PERIOD_CYC slot to avoid acoustic crosstalk. Synchronises each echo input, measures the echo high time in clk cycles with a timeout, and reports one result per slot to the downstream crash-detect logic.

---
 rtl/ultrasonic_multi_ranger_if.sv | 28 ++
 rtl/ultrasonic_multi_ranger.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_multi_ranger_if.sv
// Control, echo and result signals between the ranging controller and its sensors/consumer.
// The master drives enable/mode/select and the raw echoes; the slave (ranger) returns triggers and results.
interface ultrasonic_multi_ranger_if #(
  parameter int NCH   = 4,
  parameter int CH_W  = 2,
  parameter int CNT_W = 24
);
  logic             en;
  logic             mode;
  logic [CH_W-1:0]  sel_ch;
  logic [NCH-1:0]   echo;
  logic [NCH-1:0]   trig;
  logic [CNT_W-1:0] meas;
  logic [CH_W-1:0]  meas_ch;
  logic             meas_valid;
  logic             timeout;
  logic             busy;

  modport master (
    output en, mode, sel_ch, echo,
    input  trig, meas, meas_ch, meas_valid, timeout, busy
  );

  modport slave (
    input  en, mode, sel_ch, echo,
    output trig, meas, meas_ch, meas_valid, timeout, busy
  );
endinterface

// File: rtl/ultrasonic_multi_ranger.sv
// Multi-channel ultrasonic ranger: one trigger per PERIOD_CYC slot, echo width measured with timeout.
// Result strobe lands 3 cycles after the raw echo fall; no backpressure, the consumer must take every strobe.
module ultrasonic_multi_ranger #(
  parameter int NCH         = 4,
  parameter int CH_W        = 2,
  parameter int TRIG_CYC    = 500,
  parameter int PERIOD_CYC  = 3000000,
  parameter int TIMEOUT_CYC = 1500000,
  parameter int CNT_W       = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  ultrasonic_multi_ranger_if.slave rng
);
  localparam int SLOT_W = $clog2(PERIOD_CYC);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_TRIG      = 3'd1;
  localparam logic [2:0] S_WAIT_RISE = 3'd2;
  localparam logic [2:0] S_MEASURE   = 3'd3;
  localparam logic [2:0] S_HOLDOFF   = 3'd4;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PERIOD_CYC - 1);
  localparam logic [SLOT_W-1:0] TRIG_LAST = SLOT_W'(TRIG_CYC - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NCH - 1);
  localparam logic [CH_W:0]     NCH_L     = (CH_W + 1)'(NCH);

  logic [2:0]        state_q, state_d;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]  echo_cnt_q, echo_cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [NCH-1:0]    sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0]  meas_q, meas_d;
  logic [CH_W-1:0]   meas_ch_q, meas_ch_d;
  logic              meas_valid_q, meas_valid_d;
  logic              timeout_q, timeout_d;

  logic              echo_cur, echo_prev, echo_rise, echo_fall;
  logic              to_hit, start_slot;
  logic [CH_W-1:0]   slot_ch;
  logic [NCH-1:0]    trig_vec;

  // Only the channel owning the current slot is observed; other echoes are crosstalk.
  assign echo_cur  = sync2_q[ch_q];
  assign echo_prev = prev_q[ch_q];
  assign echo_rise = echo_cur & ~echo_prev;
  assign echo_fall = ~echo_cur & echo_prev;
  assign to_hit    = (to_cnt_q == TO_LAST);

  always_comb begin
    slot_ch = '0;
    if (rng.mode) begin
      slot_ch = rr_q;
    end else if ({1'b0, rng.sel_ch} < NCH_L) begin
      slot_ch = rng.sel_ch;
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_cnt_d   = slot_cnt_q;
    to_cnt_d     = to_cnt_q;
    echo_cnt_d   = echo_cnt_q;
    ch_d         = ch_q;
    rr_d         = rr_q;
    meas_d       = meas_q;
    meas_ch_d    = meas_ch_q;
    meas_valid_d = 1'b0;
    timeout_d    = 1'b0;
    start_slot   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rng.en) begin
          start_slot = 1'b1;
        end
      end
      S_TRIG: begin
        slot_cnt_d = slot_cnt_q + 1'b1;
        if (slot_cnt_q == TRIG_LAST) begin
          state_d  = S_WAIT_RISE;
          to_cnt_d = '0;
        end
      end
      S_WAIT_RISE: begin
        slot_cnt_d = slot_cnt_q + 1'b1;
        to_cnt_d   = to_cnt_q + 1'b1;
        if (to_hit) begin
          meas_d       = '1;
          meas_ch_d    = ch_q;
          meas_valid_d = 1'b1;
          timeout_d    = 1'b1;
          state_d      = S_HOLDOFF;
        end else if (echo_rise) begin
          echo_cnt_d = CNT_W'(1);
          state_d    = S_MEASURE;
        end
      end
      S_MEASURE: begin
        slot_cnt_d = slot_cnt_q + 1'b1;
        to_cnt_d   = to_cnt_q + 1'b1;
        // A fall coinciding with the timeout still counts as a completed echo.
        if (echo_fall) begin
          meas_d       = echo_cnt_q;
          meas_ch_d    = ch_q;
          meas_valid_d = 1'b1;
          state_d      = S_HOLDOFF;
        end else if (to_hit) begin
          meas_d       = '1;
          meas_ch_d    = ch_q;
          meas_valid_d = 1'b1;
          timeout_d    = 1'b1;
          state_d      = S_HOLDOFF;
        end else if (echo_cur && (echo_cnt_q != '1)) begin
          echo_cnt_d = echo_cnt_q + 1'b1;
        end
      end
      S_HOLDOFF: begin
        slot_cnt_d = slot_cnt_q + 1'b1;
        if (slot_cnt_q == SLOT_LAST) begin
          if (rng.en) begin
            start_slot = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Channel and pointer only move at a slot boundary.
    if (start_slot) begin
      state_d    = S_TRIG;
      slot_cnt_d = '0;
      ch_d       = slot_ch;
      if (rng.mode) begin
        rr_d = (rr_q == CH_LAST) ? '0 : rr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      slot_cnt_q   <= '0;
      to_cnt_q     <= '0;
      echo_cnt_q   <= '0;
      ch_q         <= '0;
      rr_q         <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      meas_q       <= '0;
      meas_ch_q    <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      to_cnt_q     <= to_cnt_d;
      echo_cnt_q   <= echo_cnt_d;
      ch_q         <= ch_d;
      rr_q         <= rr_d;
      sync1_q      <= rng.echo;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      meas_q       <= meas_d;
      meas_ch_q    <= meas_ch_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    trig_vec = '0;
    if (state_q == S_TRIG) begin
      trig_vec[ch_q] = 1'b1;
    end
  end

  assign rng.trig       = trig_vec;
  assign rng.meas       = meas_q;
  assign rng.meas_ch    = meas_ch_q;
  assign rng.meas_valid = meas_valid_q;
  assign rng.timeout    = timeout_q;
  assign rng.busy       = (state_q != S_IDLE);

endmodule
